// File: rtl/beatmap_pkg.sv
// Shared constants and FSM state encoding for the beatmap note-ROM reader.
package beatmap_pkg;

   localparam int ADDR_W    = 13;
   localparam int LANES     = 4;
   localparam int NUM_NOTES = 17;

   typedef enum logic [2:0] {
      IDLE,
      FETCH_A,
      FETCH_D,
      WAIT_BEAT,
      DONE
   } seq_state_t;

endpackage

// File: rtl/beat_timer.sv
// Free-running beat counter: counts 0..TICKS_PER_BEAT-1 while run is high and
// pulses tick in the cycle it sits on the last count.
module beat_timer #(
   parameter int TICKS_PER_BEAT = 12500000
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic run,
   output logic tick
);

   localparam int CNT_W = (TICKS_PER_BEAT > 2) ? $clog2(TICKS_PER_BEAT) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS_PER_BEAT - 1);

   logic [CNT_W-1:0] count;

   assign tick = run && (count == LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (tick) begin
         count <= '0;
      end else if (run) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/beatmap_sequencer.sv
// Walks the note ROM one entry per beat, prefetching the next entry right after
// each beat so the lane mask is buffered well before the following beat fires.
module beatmap_sequencer
   import beatmap_pkg::*;
#(
   parameter int TICKS_PER_BEAT = 12500000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              pause,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [LANES-1:0]  rom_data,
   output logic              beat_tick,
   output logic              note_valid,
   output logic [LANES-1:0]  note_lanes,
   output logic [ADDR_W-1:0] beat_idx,
   output logic              busy,
   output logic              done
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_NOTES - 1);

   seq_state_t       state;
   seq_state_t       state_nxt;
   logic [LANES-1:0] buffer;
   logic             timer_tick;
   logic             start_ok;
   logic             last_entry;

   assign busy       = (state != IDLE) && (state != DONE);
   assign done       = (state == DONE);
   assign start_ok   = start && ((state == IDLE) || (state == DONE));
   assign last_entry = (rom_addr == LAST_ADDR);

   // Gate with WAIT_BEAT so a beat can never be emitted from a half-finished fetch.
   assign beat_tick  = timer_tick && (state == WAIT_BEAT);
   assign note_valid = beat_tick && (buffer != '0);

   beat_timer #(
      .TICKS_PER_BEAT (TICKS_PER_BEAT)
   ) u_beat_timer (
      .clk   (clk),
      .reset (reset),
      .clear (start_ok),
      .run   (busy && !pause),
      .tick  (timer_tick)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               state_nxt = FETCH_A;
            end
         end
         FETCH_A:   state_nxt = FETCH_D;
         FETCH_D:   state_nxt = WAIT_BEAT;
         WAIT_BEAT: begin
            if (beat_tick) begin
               state_nxt = last_entry ? DONE : FETCH_A;
            end
         end
         default:   state_nxt = IDLE;
      endcase
   end

   // rom_addr is held through FETCH_A so the ROM samples it on that cycle's closing edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rom_addr   <= '0;
         buffer     <= '0;
         note_lanes <= '0;
         beat_idx   <= '0;
      end else begin
         if (start_ok) begin
            rom_addr <= '0;
         end else if (beat_tick && !last_entry) begin
            rom_addr <= rom_addr + 1'b1;
         end
         if (state == FETCH_D) begin
            buffer <= rom_data;
         end
         if (beat_tick) begin
            note_lanes <= buffer;
            beat_idx   <= rom_addr;
         end
      end
   end

endmodule

// File: tb/tb_beatmap_sequencer.sv
// Directed bench for beatmap_sequencer with TICKS_PER_BEAT=8 and a 1-cycle registered ROM.
module tb_beatmap_sequencer;

   localparam int T = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        pause;
   logic [12:0] rom_addr;
   logic [3:0]  rom_data;
   logic        beat_tick;
   logic        note_valid;
   logic [3:0]  note_lanes;
   logic [12:0] beat_idx;
   logic        busy;
   logic        done;

   logic [3:0]  rom [0:16];
   int          cyc = 0;
   int          n_checks = 0;
   int          n_fail = 0;

   int          tick_t [$];
   logic        vld_q [$];
   logic [3:0]  lanes_q [$];
   logic [12:0] idx_q [$];
   logic        prev_tick = 1'b0;
   logic        done_prev = 1'b0;
   int          done_rise = -1;

   beatmap_sequencer #(
      .TICKS_PER_BEAT (T)
   ) dut (
      .clk        (clk),
      .reset      (rst),
      .start      (start),
      .pause      (pause),
      .rom_addr   (rom_addr),
      .rom_data   (rom_data),
      .beat_tick  (beat_tick),
      .note_valid (note_valid),
      .note_lanes (note_lanes),
      .beat_idx   (beat_idx),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc      <= cyc + 1;
      rom_data <= rom[rom_addr[4:0]];
   end

   // note_lanes/beat_idx are registered on the beat, so they are captured one cycle later.
   always @(negedge clk) begin
      if (prev_tick) begin
         lanes_q.push_back(note_lanes);
         idx_q.push_back(beat_idx);
      end
      prev_tick = beat_tick;
      if (beat_tick) begin
         tick_t.push_back(cyc);
         vld_q.push_back(note_valid);
      end
      if (done && !done_prev) done_rise = cyc;
      done_prev = done;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_beat(input string tag, input int i, input int exp_t,
                             input logic [3:0] exp_lanes, input int exp_idx, input logic exp_vld);
      if (i < tick_t.size() && i < lanes_q.size()) begin
         check({tag, "_time"}, tick_t[i], exp_t);
         check({tag, "_valid"}, vld_q[i], exp_vld);
         check({tag, "_lanes"}, lanes_q[i], exp_lanes);
         check({tag, "_idx"}, idx_q[i], exp_idx);
      end else begin
         check({tag, "_present"}, tick_t.size(), i + 1);
      end
   endtask

   task automatic to_cycle(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_start(output int t);
      @(posedge clk);
      #1;
      start = 1'b1;
      t = cyc;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic clear_q();
      tick_t.delete();
      vld_q.delete();
      lanes_q.delete();
      idx_q.delete();
      done_rise = -1;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int t0;
      logic [3:0] keep3;

      rom[0]  = 4'b1111; rom[1]  = 4'b1010; rom[2]  = 4'b0110; rom[3]  = 4'b0001;
      rom[4]  = 4'b1000; rom[5]  = 4'b0100; rom[6]  = 4'b0010; rom[7]  = 4'b0011;
      rom[8]  = 4'b1100; rom[9]  = 4'b0101; rom[10] = 4'b1001; rom[11] = 4'b0111;
      rom[12] = 4'b1110; rom[13] = 4'b1011; rom[14] = 4'b1101; rom[15] = 4'b0110;
      rom[16] = 4'b1001;
      rst = 1'b1; start = 1'b0; pause = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_rom_addr", rom_addr, 0);
      check("rst_beat_tick", beat_tick, 0);
      check("rst_note_valid", note_valid, 0);
      check("rst_note_lanes", note_lanes, 0);
      check("rst_beat_idx", beat_idx, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Full song: first beats and end-of-song behaviour
      clear_q();
      do_start(t0);
      to_cycle(t0 + 2);
      @(negedge clk);
      check("s1_busy", busy, 1);
      to_cycle(t0 + 150);
      @(negedge clk);
      check_beat("s1_b0", 0, t0 + 8,  4'b1111, 0, 1'b1);
      check_beat("s1_b1", 1, t0 + 16, 4'b1010, 1, 1'b1);
      check_beat("s1_b2", 2, t0 + 24, 4'b0110, 2, 1'b1);
      check_beat("s2_b16", 16, t0 + 136, 4'b1001, 16, 1'b1);
      check("s2_tick_count", tick_t.size(), 17);
      check("s2_done_rise", done_rise, t0 + 137);
      check("s2_done", done, 1);
      check("s2_busy", busy, 0);
      check("s2_rom_addr", rom_addr, 16);

      // Empty entry 3, restarted straight from DONE
      keep3 = rom[3];
      rom[3] = 4'b0000;
      clear_q();
      do_start(t0);
      to_cycle(t0 + 50);
      @(negedge clk);
      check("s3_done_cleared", done, 0);
      check_beat("s3_b2", 2, t0 + 24, 4'b0110, 2, 1'b1);
      check_beat("s3_b3", 3, t0 + 32, 4'b0000, 3, 1'b0);
      check_beat("s3_b4", 4, t0 + 40, 4'b1000, 4, 1'b1);
      rom[3] = keep3;
      do_reset();

      // Pause for cycles 11..15 between beat 0 and beat 1
      clear_q();
      do_start(t0);
      to_cycle(t0 + 11);
      pause = 1'b1;
      to_cycle(t0 + 16);
      pause = 1'b0;
      to_cycle(t0 + 35);
      @(negedge clk);
      check("s4_tick_count", tick_t.size(), 3);
      check_beat("s4_b0", 0, t0 + 8,  4'b1111, 0, 1'b1);
      check_beat("s4_b1", 1, t0 + 21, 4'b1010, 1, 1'b1);
      check_beat("s4_b2", 2, t0 + 29, 4'b0110, 2, 1'b1);
      do_reset();

      // Stray start pulses during playback
      clear_q();
      do_start(t0);
      to_cycle(t0 + 3);
      start = 1'b1;
      to_cycle(t0 + 4);
      start = 1'b0;
      to_cycle(t0 + 20);
      start = 1'b1;
      to_cycle(t0 + 21);
      start = 1'b0;
      to_cycle(t0 + 30);
      @(negedge clk);
      check("s5_tick_count", tick_t.size(), 3);
      check_beat("s5_b0", 0, t0 + 8,  4'b1111, 0, 1'b1);
      check_beat("s5_b1", 1, t0 + 16, 4'b1010, 1, 1'b1);
      check_beat("s5_b2", 2, t0 + 24, 4'b0110, 2, 1'b1);
      do_reset();

      // Reset mid-song, then replay
      clear_q();
      do_start(t0);
      to_cycle(t0 + 30);
      rst = 1'b1;
      @(negedge clk);
      check("s6_note_lanes", note_lanes, 0);
      check("s6_beat_idx", beat_idx, 0);
      check("s6_rom_addr", rom_addr, 0);
      check("s6_busy", busy, 0);
      check("s6_done", done, 0);
      check("s6_beat_tick", beat_tick, 0);
      to_cycle(t0 + 32);
      rst = 1'b0;
      to_cycle(t0 + 60);
      @(negedge clk);
      check("s6_tick_count", tick_t.size(), 3);
      check("s6_idle_busy", busy, 0);
      clear_q();
      do_start(t0);
      to_cycle(t0 + 12);
      @(negedge clk);
      check_beat("s6_replay_b0", 0, t0 + 8, 4'b1111, 0, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
